// File: rtl/palette_index_encoder.sv
// Nearest-colour palette search: maps an RGB444 pixel to the palette index with the
// smallest Manhattan distance, scanning one entry per clock over a writable palette copy.
module palette_index_encoder #(
  parameter int ENTRIES = 256,
  parameter int IDX_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [11:0]      wr_rgb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_rgb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [5:0]       out_dist,
  output logic             out_exact
);

  // Handshakes: a query transfers on an edge where in_valid && in_ready; a result
  // transfers on an edge where out_valid && out_ready. Results stay stable until taken.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   ENTRIES_W = (IDX_W + 1)'(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);
  localparam logic [5:0]       DIST_MAX  = 6'd63;

  logic [11:0] pal [ENTRIES];

  state_t           state, state_d;
  logic [IDX_W-1:0] cnt, cnt_d;
  logic [11:0]      query, query_d;
  logic [5:0]       best_dist, best_dist_d;
  logic [IDX_W-1:0] best_idx, best_idx_d;
  logic             out_valid_d;
  logic [IDX_W-1:0] out_index_d;
  logic [5:0]       out_dist_d;
  logic             out_exact_d;

  logic [5:0]       cur_dist;
  logic             better;
  logic [5:0]       upd_dist;
  logic [IDX_W-1:0] upd_idx;

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [5:0] rgb_dist(input logic [11:0] a, input logic [11:0] b);
    return {2'b00, abs_diff(a[11:8], b[11:8])}
         + {2'b00, abs_diff(a[7:4],  b[7:4])}
         + {2'b00, abs_diff(a[3:0],  b[3:0])};
  endfunction

  // Palette writes are independent of the search; a same-cycle read sees the old value.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) pal[i] <= 12'h000;
    end else if (wr_en && ({1'b0, wr_addr} < ENTRIES_W)) begin
      pal[wr_addr] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      query     <= 12'h000;
      best_dist <= DIST_MAX;
      best_idx  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_dist  <= 6'd0;
      out_exact <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      query     <= query_d;
      best_dist <= best_dist_d;
      best_idx  <= best_idx_d;
      out_valid <= out_valid_d;
      out_index <= out_index_d;
      out_dist  <= out_dist_d;
      out_exact <= out_exact_d;
    end
  end

  // Strict less-than keeps the lower index on ties, since entries are visited in order.
  assign cur_dist = rgb_dist(query, pal[cnt]);
  assign better   = cur_dist < best_dist;
  assign upd_dist = better ? cur_dist : best_dist;
  assign upd_idx  = better ? cnt : best_idx;
  assign in_ready = (state == IDLE);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    query_d     = query;
    best_dist_d = best_dist;
    best_idx_d  = best_idx;
    out_valid_d = out_valid;
    out_index_d = out_index;
    out_dist_d  = out_dist;
    out_exact_d = out_exact;
    case (state)
      IDLE: begin
        if (in_valid) begin
          query_d     = in_rgb;
          cnt_d       = '0;
          best_dist_d = DIST_MAX;
          best_idx_d  = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        best_dist_d = upd_dist;
        best_idx_d  = upd_idx;
        // An exact hit cannot be beaten, so the scan stops there.
        if ((cur_dist == 6'd0) || (cnt == LAST_IDX)) begin
          out_index_d = upd_idx;
          out_dist_d  = upd_dist;
          out_exact_d = (upd_dist == 6'd0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_palette_index_encoder.sv
// Self-checking bench for palette_index_encoder: directed scenarios plus randomized
// palettes and queries checked against a brute-force nearest-colour model.
module tb_palette_index_encoder;

  localparam int ENTRIES = 256;
  localparam int IDX_W   = 8;
  localparam int W       = IDX_W + 7;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_addr = '0;
  logic [11:0]      wr_rgb = 12'h000;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [11:0]      in_rgb = 12'h000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_index;
  logic [5:0]       out_dist;
  logic             out_exact;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] m_pal [ENTRIES];
  logic [W-1:0] exp_q [$];

  palette_index_encoder #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_dist(out_dist), .out_exact(out_exact)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int chan_dist(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int colour_dist(input logic [11:0] a, input logic [11:0] b);
    return chan_dist(int'(a[11:8]), int'(b[11:8])) + chan_dist(int'(a[7:4]), int'(b[7:4]))
         + chan_dist(int'(a[3:0]), int'(b[3:0]));
  endfunction

  task automatic do_reset();
    Reset_n = 1'b0;
    in_valid = 1'b0;
    wr_en = 1'b0;
    out_ready = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_dist", out_dist, 0);
    check("rst_out_exact", out_exact, 0);
    Reset_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) m_pal[i] = 12'h000;
  endtask

  task automatic write_pal(input int addr, input logic [11:0] rgb);
    wr_en = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
    if (addr < ENTRIES) m_pal[addr] = rgb;
  endtask

  task automatic fill_pal(input logic [11:0] rgb);
    for (int i = 0; i < ENTRIES; i++) write_pal(i, rgb);
  endtask

  // Issues one query, checks latency and result, holds the result for `hold` cycles.
  task automatic query(input logic [11:0] rgb, input int hold);
    int d [ENTRIES];
    int min_d;
    int min_i;
    int exp_lat;
    int n;
    logic [W-1:0] e;
    min_d = 1000;
    for (int i = 0; i < ENTRIES; i++) begin
      d[i] = colour_dist(rgb, m_pal[i]);
      if (d[i] < min_d) min_d = d[i];
    end
    min_i = -1;
    for (int i = ENTRIES - 1; i >= 0; i--) if (d[i] == min_d) min_i = i;
    exp_lat = (min_d == 0) ? min_i + 1 : ENTRIES;
    exp_q.push_back({IDX_W'(min_i), 6'(min_d), (min_d == 0)});

    n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      void'(exp_q.pop_front());
      return;
    end
    in_valid = 1'b1;
    in_rgb = rgb;
    tick();
    in_valid = 1'b0;
    in_rgb = 12'($urandom);
    n = 0;
    while (!out_valid && n < ENTRIES + 20) begin tick(); n++; end
    e = exp_q.pop_front();
    check("out_valid", out_valid, 1);
    if (!out_valid) return;
    check("latency", n, exp_lat);
    check("out_index", out_index, e[W-1:7]);
    check("out_dist", out_dist, e[6:1]);
    check("out_exact", out_exact, e[0]);
    for (int h = 0; h < hold; h++) begin
      if (h == 3) begin
        in_valid = 1'b1;
        in_rgb = 12'($urandom);
      end
      tick();
      in_valid = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_index", out_index, e[W-1:7]);
      check("hold_dist", out_dist, e[6:1]);
      check("hold_exact", out_exact, e[0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("taken_valid", out_valid, 0);
    check("taken_in_ready", in_ready, 1);
  endtask

  initial begin
    do_reset();
    query(12'h000, 0);

    fill_pal(12'hFFF);
    write_pal(5, 12'hED1);
    query(12'hED1, 0);

    fill_pal(12'hFFF);
    write_pal(0, 12'h000);
    write_pal(1, 12'hF00);
    query(12'hE10, 2);

    fill_pal(12'hFFF);
    write_pal(3, 12'h222);
    write_pal(7, 12'h444);
    query(12'h333, 10);
    query(12'h444, 0);

    // Abort a full-length scan partway through with a reset.
    fill_pal(12'hFFF);
    in_valid = 1'b1;
    in_rgb = 12'h000;
    tick();
    in_valid = 1'b0;
    repeat (100) tick();
    check("midscan_valid", out_valid, 0);
    Reset_n = 1'b0;
    tick();
    check("abort_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    Reset_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) m_pal[i] = 12'h000;
    repeat (3) begin
      tick();
      check("abort_quiet", out_valid, 0);
    end
    query(12'h000, 0);

    for (int i = 0; i < ENTRIES; i++) write_pal(i, 12'($urandom));
    for (int q = 0; q < 24; q++) begin
      logic [11:0] rgb;
      repeat ($urandom_range(1, 12)) write_pal(int'($urandom_range(0, ENTRIES - 1)), 12'($urandom));
      if ($urandom_range(0, 2) == 0) rgb = 12'($urandom);
      else rgb = m_pal[$urandom_range(0, ENTRIES - 1)];
      query(rgb, int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
